// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: decoder/flag inputs, LUT loader port and PC/status outputs.
// FETCH_LINK_REG_EN adds the ret_en request and the link register output.
interface fetch_unit_if #(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 5
);
    logic                 start;
    logic                 branch_en;
    logic                 branch_cond;
    logic                 flag_in;
    logic [LUT_IDX_W-1:0] lut_idx;
    logic                 halt_in;
    logic                 lut_we;
    logic [LUT_IDX_W-1:0] lut_waddr;
    logic [PC_W-1:0]      lut_wdata;
    logic [PC_W-1:0]      pc;
    logic                 running;
    logic                 done;
    logic                 branch_taken;
`ifdef FETCH_LINK_REG_EN
    logic                 ret_en;
    logic [PC_W-1:0]      link;

    modport master (
        output start, branch_en, branch_cond, flag_in, lut_idx, halt_in,
               lut_we, lut_waddr, lut_wdata, ret_en,
        input  pc, running, done, branch_taken, link
    );
    modport slave (
        input  start, branch_en, branch_cond, flag_in, lut_idx, halt_in,
               lut_we, lut_waddr, lut_wdata, ret_en,
        output pc, running, done, branch_taken, link
    );
`else
    modport master (
        output start, branch_en, branch_cond, flag_in, lut_idx, halt_in,
               lut_we, lut_waddr, lut_wdata,
        input  pc, running, done, branch_taken
    );
    modport slave (
        input  start, branch_en, branch_cond, flag_in, lut_idx, halt_in,
               lut_we, lut_waddr, lut_wdata,
        output pc, running, done, branch_taken
    );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Program counter, branch-target LUT and run/halt sequencer for the fetch stage.
// Optional macro FETCH_LINK_REG_EN adds a link register with ret_en return.
//
// state  | meaning
// S_IDLE | out of reset, pc holds until start
// S_RUN  | executing, pc advances / branches every cycle
// S_HALT | program done, pc holds at halt address, done=1
module fetch_unit #(
    parameter int PC_W       = 10,
    parameter int LUT_IDX_W  = 5,
    parameter int START_ADDR = 0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.slave  bus
);
    localparam int LUT_N = 2 ** LUT_IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] lut_q [LUT_N];
    logic [PC_W-1:0] lut_rd;
    logic            run;
    logic            taken;
`ifdef FETCH_LINK_REG_EN
    logic [PC_W-1:0] link_q, link_d;
`endif

    assign run    = (state_q == S_RUN);
    assign pc_inc = pc_q + PC_W'(1);
    assign lut_rd = lut_q[bus.lut_idx];
    assign taken  = run & bus.branch_en & (bus.flag_in == bus.branch_cond);

    assign bus.pc           = pc_q;
    assign bus.running      = run;
    assign bus.done         = (state_q == S_HALT);
    assign bus.branch_taken = taken;
`ifdef FETCH_LINK_REG_EN
    assign bus.link         = link_q;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef FETCH_LINK_REG_EN
        link_d  = link_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = PC_W'(START_ADDR);
                end
            end
            S_RUN: begin
                if (bus.start) begin
                    pc_d = PC_W'(START_ADDR);
                end else if (bus.halt_in) begin
                    state_d = S_HALT;
`ifdef FETCH_LINK_REG_EN
                end else if (bus.ret_en) begin
                    pc_d = link_q;
`endif
                end else if (taken) begin
                    pc_d = lut_rd;
`ifdef FETCH_LINK_REG_EN
                    link_d = pc_inc;
`endif
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
`ifdef FETCH_LINK_REG_EN
            link_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef FETCH_LINK_REG_EN
            link_q  <= link_d;
`endif
        end
    end

    // Read above is combinational from stored contents, so a same-cycle write is seen next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else if (bus.lut_we) begin
            lut_q[bus.lut_waddr] <= bus.lut_wdata;
        end
    end
endmodule
